// File: rtl/pio_event_sequencer.sv
// pio_event_sequencer
//   Avalon-MM master that drives the switch/button PIO slave. After reset it sets irq_mask,
//   clears stale edge_capture bits, and then services the PIO irq (read edge_capture, then
//   clear it). It also polls the data register every POLL_DIV cycles. Captured edges go to
//   game logic through a valid/ready buffer. Polled levels appear as a one-cycle strobed
//   snapshot.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   pio_address       PIO register select (0 data, 2 irq_mask, 3 edge_capture)
//   pio_chipselect    PIO chipselect
//   pio_write_n       PIO write strobe, active low
//   pio_writedata     PIO write data (only bits [WIDTH-1:0] are ever non-zero)
//   pio_readdata      PIO read data, one cycle after the read access
//   pio_irq           PIO interrupt request
//   enable            1: service irq and polls; 0: finish current sequence, then stay idle
//   event_valid       event_bits holds at least one pending edge
//   event_ready       consumer accepts event_bits when event_valid & event_ready
//   event_bits        accumulated captured edges
//   level             last polled PIO data value
//   level_valid       one-cycle strobe: level updated
//   busy              FSM is not idle
module pio_event_sequencer #(
  parameter int unsigned       WIDTH         = 3,
  parameter logic [WIDTH-1:0]  IRQ_MASK_INIT = 3'b111,
  parameter int unsigned       POLL_DIV      = 50000
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic             enable,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_bits,
  output logic [WIDTH-1:0] level,
  output logic             level_valid,
  output logic             busy
);

  localparam logic [31:0] PollReload = (POLL_DIV == 0) ? 32'd0 : 32'(POLL_DIV - 1);

  typedef enum logic [3:0] {
    StRstWait,
    StInitMask,
    StInitClr,
    StIdle,
    StRdEc,
    StCapEc,
    StClrEc,
    StRdLvl,
    StCapLvl
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      poll_cnt_q, poll_cnt_d;
  logic             poll_req_q, poll_req_d;
  logic [WIDTH-1:0] event_bits_q, event_bits_d;
  logic             event_valid_q, event_valid_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             level_valid_q, level_valid_d;

  logic [WIDTH-1:0] cap;
  logic             handshake;
  logic             poll_expire;

  assign cap         = pio_readdata[WIDTH-1:0];
  assign handshake   = event_valid_q & event_ready;
  assign poll_expire = (POLL_DIV != 0) && (poll_cnt_q == '0);

  if (WIDTH < 32) begin : g_unused_rdata
    logic unused_rdata;
    assign unused_rdata = ^pio_readdata[31:WIDTH];
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRstWait:  state_d = StInitMask;
      StInitMask: state_d = StInitClr;
      StInitClr:  state_d = StIdle;
      StIdle: begin
        // irq takes priority over a pending poll
        if (enable && pio_irq) begin
          state_d = StRdEc;
        end else if (enable && poll_req_q) begin
          state_d = StRdLvl;
        end
      end
      StRdEc:   state_d = StCapEc;
      StCapEc:  state_d = StClrEc;
      StClrEc:  state_d = StIdle;
      StRdLvl:  state_d = StCapLvl;
      StCapLvl: state_d = StIdle;
      default:  state_d = StRstWait;
    endcase
  end

  // Moore bus decode
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = 2'd0;
    pio_writedata  = 32'd0;
    unique case (state_q)
      StInitMask: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = 2'd2;
        pio_writedata  = {{(32 - WIDTH){1'b0}}, IRQ_MASK_INIT};
      end
      StInitClr, StClrEc: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = 2'd3;
      end
      StRdEc, StCapEc: begin
        pio_chipselect = 1'b1;
        pio_address    = 2'd3;
      end
      StRdLvl, StCapLvl: begin
        pio_chipselect = 1'b1;
      end
      default: ;
    endcase
  end

  // Poll timer: expiries while a poll is already pending collapse into a single request.
  // A fresh expiry wins over the clear in StRdLvl, so no poll period is lost.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    poll_req_d = poll_req_q;
    if (POLL_DIV != 0) begin
      poll_cnt_d = poll_expire ? PollReload : poll_cnt_q - 32'd1;
    end
    if (state_q == StRdLvl) begin
      poll_req_d = 1'b0;
    end
    if (poll_expire) begin
      poll_req_d = 1'b1;
    end
  end

  // Event buffer. A handshake clears the bits. A capture arriving in the same cycle survives
  // alone. Captures that are not yet accepted are OR-merged into the pending bits.
  always_comb begin
    event_bits_d = event_bits_q;
    if (handshake) begin
      event_bits_d = '0;
    end
    if (state_q == StCapEc) begin
      event_bits_d = event_bits_d | cap;
    end
    event_valid_d = |event_bits_d;
  end

  always_comb begin
    level_d       = level_q;
    level_valid_d = 1'b0;
    if (state_q == StCapLvl) begin
      level_d       = cap;
      level_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRstWait;
      poll_cnt_q    <= PollReload;
      poll_req_q    <= 1'b0;
      event_bits_q  <= '0;
      event_valid_q <= 1'b0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      poll_req_q    <= poll_req_d;
      event_bits_q  <= event_bits_d;
      event_valid_q <= event_valid_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign event_bits  = event_bits_q;
  assign event_valid = event_valid_q;
  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_pio_event_sequencer.sv
module tb_pio_event_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        enable;
  logic        event_valid;
  logic        event_ready;
  logic [2:0]  event_bits;
  logic [2:0]  level;
  logic        level_valid;
  logic        busy;

  always #5 clk = ~clk;

  pio_event_sequencer #(
    .WIDTH         (3),
    .IRQ_MASK_INIT (3'b111),
    .POLL_DIV      (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .pio_irq        (pio_irq),
    .enable         (enable),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_bits     (event_bits),
    .level          (level),
    .level_valid    (level_valid),
    .busy           (busy)
  );

  // PIO slave model: falling-edge capture, write to edge_capture clears it (clear wins),
  // registered read data.
  logic       reset_n;
  logic [2:0] pio_in, pio_in_d1, pio_ec, pio_mask;
  assign reset_n = ~reset;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_in_d1    <= 3'b000;
      pio_ec       <= 3'b000;
      pio_mask     <= 3'b000;
      pio_readdata <= 32'd0;
    end else begin
      pio_in_d1 <= pio_in;
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) pio_ec <= 3'b000;
      else pio_ec <= pio_ec | (pio_in_d1 & ~pio_in);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask <= pio_writedata[2:0];
      if (pio_chipselect && pio_write_n) begin
        case (pio_address)
          2'd0:    pio_readdata <= {29'd0, pio_in};
          2'd2:    pio_readdata <= {29'd0, pio_mask};
          2'd3:    pio_readdata <= {29'd0, pio_ec};
          default: pio_readdata <= 32'd0;
        endcase
      end else begin
        pio_readdata <= 32'd0;
      end
    end
  end
  assign pio_irq = |(pio_ec & pio_mask);

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (12) tick();
  endtask

  task automatic check_bus(input string nm, input logic cs, input logic wn, input logic [1:0] a,
                           input logic [31:0] wd);
    check({nm, "_cs"}, 32'(pio_chipselect), 32'(cs));
    check({nm, "_wn"}, 32'(pio_write_n), 32'(wn));
    check({nm, "_addr"}, 32'(pio_address), 32'(a));
    check({nm, "_wdata"}, pio_writedata, wd);
  endtask

  task automatic wait_irq_idle(input string nm);
    int n = 0;
    while (!(pio_irq && !busy) && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_irq_idle_seen"}, 32'(pio_irq && !busy), 32'd1);
  endtask

  task automatic wait_level(input string nm, input logic [2:0] exp);
    int n = 0;
    while (!level_valid && n < 30) begin
      tick();
      n++;
    end
    check({nm, "_lvl_strobe_seen"}, 32'(level_valid), 32'd1);
    check({nm, "_lvl_value"}, 32'(level), 32'(exp));
    tick();
    check({nm, "_lvl_strobe_1cyc"}, 32'(level_valid), 32'd0);
  endtask

  task automatic accept(input string nm);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    check({nm, "_acc_valid"}, 32'(event_valid), 32'd0);
    check({nm, "_acc_bits"}, 32'(event_bits), 32'd0);
    tick();
    check({nm, "_acc_nodup"}, 32'(event_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0] in_val;
    logic [2:0] exp_bits;
    bit         acc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] cur, nv, pending;
    bit         no_access, seen_ev;

    vecs[0] = '{3'b100, 3'b001, 1'b0};
    vecs[1] = '{3'b000, 3'b101, 1'b1};
    vecs[2] = '{3'b111, 3'b000, 1'b0};
    vecs[3] = '{3'b010, 3'b101, 1'b0};
    vecs[4] = '{3'b000, 3'b111, 1'b1};
    vecs[5] = '{3'b111, 3'b000, 1'b0};

    event_ready = 1'b0;
    enable      = 1'b1;
    pio_in      = 3'b111;

    // Reset values and init sequence
    repeat (3) tick();
    check_bus("rst", 1'b0, 1'b1, 2'd0, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ev_valid", 32'(event_valid), 32'd0);
    check("rst_ev_bits", 32'(event_bits), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_level_valid", 32'(level_valid), 32'd0);
    reset = 1'b0;
    check_bus("t1_wait", 1'b0, 1'b1, 2'd0, 32'd0);
    tick();
    check_bus("t1_mask", 1'b1, 1'b0, 2'd2, 32'd7);
    tick();
    check_bus("t1_clr", 1'b1, 1'b0, 2'd3, 32'd0);
    tick();
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_mask_reg", 32'(pio_mask), 32'd7);
    check("t1_no_event", 32'(event_valid), 32'd0);

    // Falling edge on bit1, latency and clear
    pio_in = 3'b101;
    wait_irq_idle("t2");
    tick();
    check_bus("t2_rdec", 1'b1, 1'b1, 2'd3, 32'd0);
    check("t2_rdec_ev", 32'(event_valid), 32'd0);
    tick();
    check_bus("t2_capec", 1'b1, 1'b1, 2'd3, 32'd0);
    check("t2_capec_ev", 32'(event_valid), 32'd0);
    tick();
    check_bus("t2_clrec", 1'b1, 1'b0, 2'd3, 32'd0);
    check("t2_ev_valid", 32'(event_valid), 32'd1);
    check("t2_ev_bits", 32'(event_bits), 32'd2);
    tick();
    check("t2_pio_ec_clr", 32'(pio_ec), 32'd0);
    check("t2_irq_low", 32'(pio_irq), 32'd0);
    accept("t2");

    // Table: edge merging, acceptance, level polling
    for (int i = 0; i < 6; i++) begin
      pio_in = vecs[i].in_val;
      settle();
      check($sformatf("vec%0d_valid", i), 32'(event_valid), 32'(vecs[i].exp_bits != 3'b000));
      check($sformatf("vec%0d_bits", i), 32'(event_bits), 32'(vecs[i].exp_bits));
      wait_level($sformatf("vec%0d", i), vecs[i].in_val);
      if (vecs[i].acc) accept($sformatf("vec%0d", i));
    end

    // enable=0 holds off service; then irq is serviced ahead of the pending poll
    enable = 1'b0;
    repeat (4) tick();
    pio_in = 3'b011;
    no_access = 1'b1;
    repeat (20) begin
      tick();
      if (pio_chipselect) no_access = 1'b0;
    end
    check("t6_no_bus", 32'(no_access), 32'd1);
    check("t6_irq_pending", 32'(pio_irq), 32'd1);
    check("t6_no_event", 32'(event_valid), 32'd0);
    enable = 1'b1;
    tick();
    check_bus("t4_rdec_first", 1'b1, 1'b1, 2'd3, 32'd0);
    tick();
    tick();
    check("t6_ev_valid", 32'(event_valid), 32'd1);
    check("t6_ev_bits", 32'(event_bits), 32'd4);
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    tick();
    check_bus("t4_rdlvl", 1'b1, 1'b1, 2'd0, 32'd0);
    tick();
    tick();
    check("t4_lvl_strobe", 32'(level_valid), 32'd1);
    check("t4_lvl_value", 32'(level), 32'd3);
    accept("t6");

    // Reset during CAP_EC discards the capture
    pio_in = 3'b010;
    wait_irq_idle("t5");
    tick();
    tick();
    check_bus("t5_capec", 1'b1, 1'b1, 2'd3, 32'd0);
    reset = 1'b1;
    #1;
    check_bus("t5_async", 1'b0, 1'b1, 2'd0, 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_ev_async", 32'(event_valid), 32'd0);
    tick();
    reset = 1'b0;
    check_bus("t5_wait", 1'b0, 1'b1, 2'd0, 32'd0);
    tick();
    check_bus("t5_mask", 1'b1, 1'b0, 2'd2, 32'd7);
    tick();
    check_bus("t5_clr", 1'b1, 1'b0, 2'd3, 32'd0);
    tick();
    check("t5_idle", 32'(busy), 32'd0);
    seen_ev = 1'b0;
    repeat (16) begin
      tick();
      if (event_valid) seen_ev = 1'b1;
    end
    check("t5_no_event", 32'(seen_ev), 32'd0);

    // Handshake in the same cycle as a capture: only the new capture remains
    pio_in = 3'b111;
    settle();
    pio_in = 3'b101;
    settle();
    check("hs_pre_bits", 32'(event_bits), 32'd2);
    pio_in = 3'b100;
    wait_irq_idle("hs");
    tick();
    tick();
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    check("hs_valid", 32'(event_valid), 32'd1);
    check("hs_bits", 32'(event_bits), 32'd1);
    accept("hs");

    // Random stimulus against a pending-set model
    cur = pio_in;
    pending = 3'b000;
    for (int i = 0; i < 40; i++) begin
      nv = 3'($urandom_range(0, 7));
      pending = pending | (cur & ~nv);
      cur = nv;
      pio_in = nv;
      settle();
      check($sformatf("rnd%0d_bits", i), 32'(event_bits), 32'(pending));
      check($sformatf("rnd%0d_valid", i), 32'(event_valid), 32'(pending != 3'b000));
      if ($urandom_range(0, 3) == 0) wait_level($sformatf("rnd%0d", i), nv);
      if ($urandom_range(0, 2) == 0) begin
        accept($sformatf("rnd%0d", i));
        pending = 3'b000;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
